hw3_alu_pipe: RTL and testbench

Parametrised, pipelined successor to the HW2 8-bit ALU. It accepts one operation per cycle through a valid/ready handshake and returns a registered `2*WIDTH`-bit result with status flags. Multiplies can run on an iterative shift-add engine, and opcode 111 drives an internal accumulator instead of returning zero. The block sits between the operand sequencer and the result writeback in the HW3 datapath.

---
 rtl/hw3_alu_pkg.sv | 18 +
 rtl/alu_mul_iter.sv | 56 +++++
 rtl/hw3_alu_pipe.sv | 157 +++++++++++++++
 tb/tb_hw3_alu_pipe.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/hw3_alu_pkg.sv
// Shared opcode values and FSM state encoding for the HW3 pipelined ALU.
package hw3_alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_ABS = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_ACC = 3'b111;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MUL_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Shift-add multiplier: one partial product per cycle, WIDTH cycles per product.
module alu_mul_iter
  import hw3_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk_p_i,
  input  logic                 reset_n_i,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int RW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  logic [RW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;
  logic             busy;

  // The start edge already consumes b[0], so cnt begins at 1 and the
  // last partial product lands on the edge where cnt == WIDTH-1.
  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        product <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
        mcand   <= {{(WIDTH-1){1'b0}}, a, 1'b0};
        mplier  <= b >> 1;
        cnt     <= CW'(1);
        busy    <= 1'b1;
      end else if (busy) begin
        if (mplier[0]) product <= product + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        if (cnt == CW'(WIDTH - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hw3_alu_pipe.sv
// Pipelined ALU: stage-1 operand register, opcode mux with flags, accumulator,
// and an optional iterative multiplier that stalls the input handshake.
module hw3_alu_pipe
  import hw3_alu_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MUL_ITER = 1
) (
  input  logic                 clk_p_i,
  input  logic                 reset_n_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [WIDTH-1:0]     data_a_i,
  input  logic [WIDTH-1:0]     data_b_i,
  input  logic [2:0]           inst_i,
  output logic                 valid_o,
  output logic [2*WIDTH-1:0]   data_o,
  output logic [2:0]           flags_o,
  output state_t               dbg_state
);

  localparam int RW   = 2 * WIDTH;
  localparam int CW   = $clog2(WIDTH);
  localparam bit ITER = (MUL_ITER != 0);

  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [2:0]       s1_op;
  logic             s1_valid;
  state_t           state;
  logic [CW-1:0]    cnt;
  logic [RW-1:0]    acc;
  logic [RW-1:0]    res;
  logic             carry;
  logic             transfer;
  logic             s1_is_iter_mul;
  logic             mul_start;
  logic             mul_done;
  logic [RW-1:0]    mul_product;

  // Handshake: a word moves on a rising edge where valid_i & ready_o; the
  // source holds its inputs until then, and valid_i alone is never captured.
  assign s1_is_iter_mul = s1_valid & (s1_op == OP_MUL) & ITER;
  assign ready_o        = (state == ST_IDLE) & ~s1_is_iter_mul;
  assign transfer       = valid_i & ready_o;
  assign mul_start      = (state == ST_IDLE) & s1_is_iter_mul;
  assign dbg_state      = state;

  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= OP_ACC;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= transfer;
      if (transfer) begin
        s1_a  <= data_a_i;
        s1_b  <= data_b_i;
        s1_op <= inst_i;
      end
    end
  end

  always_comb begin
    logic [RW-1:0]    a_ext;
    logic [RW-1:0]    b_ext;
    logic [RW-1:0]    sum;
    logic [WIDTH:0]   abs_val;
    a_ext   = {{WIDTH{1'b0}}, s1_a};
    b_ext   = {{WIDTH{1'b0}}, s1_b};
    sum     = a_ext + b_ext;
    abs_val = {1'b0, ~s1_a} + {{WIDTH{1'b0}}, 1'b1};
    res     = '0;
    carry   = 1'b0;
    case (s1_op)
      OP_ADD: begin
        res   = sum;
        carry = sum[WIDTH];
      end
      OP_SUB: res = a_ext - b_ext;
      OP_MUL: res = a_ext * b_ext;
      OP_AND: res = a_ext & b_ext;
      OP_XOR: res = a_ext ^ b_ext;
      OP_ABS: res = s1_a[WIDTH-1] ? {{(WIDTH-1){1'b0}}, abs_val} : a_ext;
      OP_SHL: res = (a_ext - b_ext) << 2;
      OP_ACC: res = s1_b[0] ? a_ext : acc + a_ext;
      default: res = '0;
    endcase
  end

  // FSM counter tracks the multiplier's iteration index so ready_o can
  // rise one cycle before the product is registered.
  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mul_start) begin
            state <= ST_MUL_BUSY;
            cnt   <= CW'(1);
          end
        end
        ST_MUL_BUSY: begin
          if (cnt == CW'(WIDTH - 1)) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  generate
    if (ITER) begin : g_iter
      alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk_p_i   (clk_p_i),
        .reset_n_i (reset_n_i),
        .start     (mul_start),
        .a         (s1_a),
        .b         (s1_b),
        .done      (mul_done),
        .product   (mul_product)
      );
    end else begin : g_comb
      assign mul_done    = 1'b0;
      assign mul_product = '0;
    end
  endgenerate

  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      flags_o <= '0;
      acc     <= '0;
    end else begin
      valid_o <= 1'b0;
      if (mul_done) begin
        data_o  <= mul_product;
        flags_o <= {1'b0, mul_product[RW-1], (mul_product == '0)};
        valid_o <= 1'b1;
      end else if (s1_valid && !s1_is_iter_mul) begin
        data_o  <= res;
        flags_o <= {carry, res[RW-1], (res == '0)};
        valid_o <= 1'b1;
        if (s1_op == OP_ACC) acc <= res;
      end
    end
  end

endmodule

// File: tb/tb_hw3_alu_pipe.sv
// Bench for hw3_alu_pipe (WIDTH=8, iterative MUL): directed cases plus random
// traffic scored against an arithmetic reference model.
module tb_hw3_alu_pipe;
  import hw3_alu_pkg::*;

  localparam int W  = 8;
  localparam int RW = 2 * W;

  logic            clk_p_i   = 1'b0;
  logic            reset_n_i = 1'b0;
  logic            valid_i   = 1'b0;
  logic [W-1:0]    data_a_i  = '0;
  logic [W-1:0]    data_b_i  = '0;
  logic [2:0]      inst_i    = '0;
  logic            ready_o;
  logic            valid_o;
  logic [RW-1:0]   data_o;
  logic [2:0]      flags_o;
  state_t          dbg_state;

  hw3_alu_pipe #(.WIDTH(W), .MUL_ITER(1)) dut (
    .clk_p_i   (clk_p_i),
    .reset_n_i (reset_n_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .data_a_i  (data_a_i),
    .data_b_i  (data_b_i),
    .inst_i    (inst_i),
    .valid_o   (valid_o),
    .data_o    (data_o),
    .flags_o   (flags_o),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_p_i = ~clk_p_i;

  int cyc = 0;
  always @(posedge clk_p_i) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [RW+2:0] exp_q[$];
  int            cyc_q[$];
  logic [RW-1:0] m_acc      = '0;
  logic [RW-1:0] last_data  = '0;
  logic [2:0]    last_flags = '0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [RW+2:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [RW-1:0] r;
    logic          c;
    int            av;
    int            bv;
    av = int'(a);
    bv = int'(b);
    c  = 1'b0;
    case (op)
      OP_ADD: begin
        r = RW'(av + bv);
        c = (av + bv) >= (1 << W);
      end
      OP_SUB: r = RW'(av - bv);
      OP_MUL: r = RW'(av * bv);
      OP_AND: r = RW'(av & bv);
      OP_XOR: r = RW'(av ^ bv);
      OP_ABS: r = (av >= (1 << (W - 1))) ? RW'((1 << W) - av) : RW'(av);
      OP_SHL: r = RW'((av - bv) * 4);
      default: begin
        r     = (bv % 2 == 1) ? RW'(av) : m_acc + RW'(av);
        m_acc = r;
      end
    endcase
    return {c, r[RW-1], (r == '0), r};
  endfunction

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input bit has_exp = 1'b0, input logic [RW+2:0] exp = '0);
    int            waited;
    logic [RW+2:0] m;
    waited   = 0;
    valid_i  = 1'b1;
    inst_i   = op;
    data_a_i = a;
    data_b_i = b;
    while (!ready_o && waited < 40) begin
      @(negedge clk_p_i);
      waited++;
    end
    if (!ready_o) begin
      n_tests++;
      n_fail++;
      $display("FAIL handshake_timeout: ready_o=%b after %0d cycles, required 1", ready_o, waited);
      valid_i = 1'b0;
      return;
    end
    m = model(op, a, b);
    exp_q.push_back(has_exp ? exp : m);
    cyc_q.push_back((op == OP_MUL) ? cyc + W + 2 : cyc + 2);
    @(negedge clk_p_i);
    valid_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_p_i);
    reset_n_i = 1'b0;
    valid_i   = 1'b0;
    exp_q.delete();
    cyc_q.delete();
    m_acc      = '0;
    last_data  = '0;
    last_flags = '0;
    @(negedge clk_p_i);
    chk("reset_data",  32'(data_o),    32'h0);
    chk("reset_flags", 32'(flags_o),   32'h0);
    chk("reset_valid", 32'(valid_o),   32'h0);
    chk("reset_ready", 32'(ready_o),   32'h1);
    chk("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    reset_n_i = 1'b1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk_p_i) begin
    logic [RW+2:0] e;
    int            c;
    if (reset_n_i) begin
      if (valid_o) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_valid: data_o=%h flags_o=%b, no result pending", data_o, flags_o);
        end else begin
          e = exp_q.pop_front();
          c = cyc_q.pop_front();
          if ({flags_o, data_o} !== e) begin
            n_fail++;
            $display("FAIL result: got flags=%b data=%h expected flags=%b data=%h",
                     flags_o, data_o, e[RW+2:RW], e[RW-1:0]);
          end
          n_tests++;
          if (cyc != c) begin
            n_fail++;
            $display("FAIL latency: result at cycle %0d expected cycle %0d", cyc, c);
          end
        end
        last_data  = data_o;
        last_flags = flags_o;
      end else begin
        n_tests++;
        if (data_o !== last_data || flags_o !== last_flags) begin
          n_fail++;
          $display("FAIL hold: data_o=%h flags_o=%b changed without valid_o, expected %h %b",
                   data_o, flags_o, last_data, last_flags);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0] ops3 [3];
    int         n;
    int         k;
    ops3[0] = OP_ADD;
    ops3[1] = OP_XOR;
    ops3[2] = OP_AND;

    do_reset();

    send(OP_ADD, 8'hFF, 8'h01, 1'b1, {3'b100, 16'h0100});
    for (int i = 0; i < 8; i++)
      send(ops3[$urandom_range(0, 2)], W'($urandom), W'($urandom));

    send(OP_SUB, 8'h01, 8'h02, 1'b1, {3'b010, 16'hFFFF});
    send(OP_SHL, 8'h01, 8'h02, 1'b1, {3'b010, 16'hFFFC});
    send(OP_SUB, 8'h33, 8'h33, 1'b1, {3'b001, 16'h0000});

    send(OP_MUL, 8'hFF, 8'hFF, 1'b1, {3'b010, 16'hFE01});
    n = 0;
    while (!ready_o && n < 40) begin
      n++;
      @(negedge clk_p_i);
    end
    chk("mul_ready_low_cycles", 32'(n), 32'd8);

    // ADD is presented while the multiplier is busy and must wait for ready_o.
    send(OP_MUL, 8'h12, 8'h34, 1'b1, {3'b000, 16'h03A8});
    send(OP_ADD, 8'h05, 8'h06, 1'b1, {3'b000, 16'h000B});

    send(OP_ABS, 8'h80, 8'h00, 1'b1, {3'b000, 16'h0080});
    send(OP_ABS, 8'hFF, 8'h00, 1'b1, {3'b000, 16'h0001});
    send(OP_ABS, 8'h7F, 8'h00, 1'b1, {3'b000, 16'h007F});

    send(OP_ACC, 8'h10, 8'h01, 1'b1, {3'b000, 16'h0010});
    send(OP_ACC, 8'hF0, 8'h00, 1'b1, {3'b000, 16'h0100});

    for (int i = 0; i < 150; i++) begin
      send(3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk_p_i);
    end

    // Reset in the middle of a multiply: the product must never appear.
    send(OP_MUL, 8'hAB, 8'hCD);
    repeat (3) @(negedge clk_p_i);
    do_reset();
    send(OP_ACC, 8'h01, 8'h00, 1'b1, {3'b000, 16'h0001});

    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(negedge clk_p_i);
      k++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
    repeat (5) @(negedge clk_p_i);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
